mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_pkg.sv | 32 +++
 rtl/mem_ctrl_extend.sv | 21 ++
 rtl/mem_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mem_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
// State encodings, access-size codes and the saturating byte counter.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IFETCH = 3'd1,
        ST_LOAD   = 3'd2,
        ST_STORE  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic [2:0] CNT_MAX = 3'd7;

    // Code 3 is unused by the load/store unit; treat it as a word.
    function automatic logic [2:0] size_bytes(input logic [1:0] size);
        case (size)
            SIZE_BYTE: return 3'd1;
            SIZE_HALF: return 3'd2;
            default:   return 3'd4;
        endcase
    endfunction

    function automatic logic [2:0] sat_inc(input logic [2:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 3'd1;
    endfunction

endpackage

// File: rtl/mem_ctrl_extend.sv
// Sign/zero extension of an assembled load value to 32 bits.
// Purely combinational; bytes above the access size are replaced.
module mem_extend
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  size_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (size_i)
            SIZE_BYTE: data_o = {{24{signed_i & data_i[7]}},  data_i[7:0]};
            SIZE_HALF: data_o = {{16{signed_i & data_i[15]}}, data_i[15:0]};
            default:   data_o = data_i;
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial RAM controller arbitrating instruction fetch and load/store.
// RAM has one cycle of read latency; all traffic is one byte per cycle.
//
//   state     | meaning
//   ----------+----------------------------------------------------------
//   ST_IDLE   | waiting for a request; load/store wins over fetch
//   ST_IFETCH | issuing 4 byte reads and assembling the instruction
//   ST_LOAD   | issuing 1/2/4 byte reads, result extended on completion
//   ST_STORE  | writing 1/2/4 bytes, may stall on a full IO buffer
//   ST_DONE   | one-cycle completion pulse; both ask inputs ignored
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full,
    input  logic        ic_ask,
    input  logic [31:0] ic_addr,
    output logic        ic_valid,
    output logic [31:0] ic_inst,
    input  logic        ls_ask,
    input  logic        ls_wr,
    input  logic [1:0]  ls_size,
    input  logic        ls_signed,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_done,
    output logic [31:0] ls_rdata
);

    state_t      state_q;
    logic [2:0]  cnt_q;
    logic [2:0]  nbytes_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [31:0] buf_q;
    logic [31:0] mem_a_q;
    logic [7:0]  dout_q;
    logic        wr_q;
    logic        ic_valid_q;
    logic [31:0] ic_inst_q;
    logic        ls_done_q;
    logic [31:0] ls_rdata_q;

    logic [1:0]  byte_sel;
    logic [31:0] buf_d;
    logic [31:0] ext_d;
    logic [2:0]  rd_next_d;
    logic [2:0]  st_idx_d;
    logic        io_stall;

    // The byte arriving now belongs to the address issued two edges ago.
    always_comb begin
        byte_sel  = cnt_q[1:0] - 2'd1;
        buf_d     = buf_q;
        buf_d[{byte_sel, 3'b000} +: 8] = mem_din;
        rd_next_d = sat_inc(cnt_q);
        st_idx_d  = wr_q ? sat_inc(cnt_q) : cnt_q;
        io_stall  = io_buffer_full && (addr_q[17:16] == 2'b11);
    end

    mem_extend u_extend (
        .data_i   (buf_d),
        .size_i   (size_q),
        .signed_i (signed_q),
        .data_o   (ext_d)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 3'd0;
            nbytes_q   <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            size_q     <= SIZE_BYTE;
            signed_q   <= 1'b0;
            buf_q      <= 32'd0;
            mem_a_q    <= 32'd0;
            dout_q     <= 8'd0;
            wr_q       <= 1'b0;
            ic_valid_q <= 1'b0;
            ic_inst_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
        end else if (rdy_in) begin
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= 3'd0;
                    buf_q <= 32'd0;
                    if (ls_ask) begin
                        addr_q   <= ls_addr;
                        wdata_q  <= ls_wdata;
                        size_q   <= ls_size;
                        signed_q <= ls_signed;
                        nbytes_q <= size_bytes(ls_size);
                        mem_a_q  <= ls_addr;
                        if (ls_wr) begin
                            state_q <= ST_STORE;
                            dout_q  <= ls_wdata[7:0];
                            wr_q    <= !(io_buffer_full && (ls_addr[17:16] == 2'b11));
                        end else begin
                            state_q <= ST_LOAD;
                        end
                    end else if (ic_ask) begin
                        state_q  <= ST_IFETCH;
                        addr_q   <= ic_addr;
                        nbytes_q <= 3'd4;
                        mem_a_q  <= ic_addr;
                    end
                end
                ST_IFETCH, ST_LOAD: begin
                    cnt_q <= rd_next_d;
                    if (cnt_q != 3'd0) begin
                        buf_q <= buf_d;
                    end
                    if (rd_next_d < nbytes_q) begin
                        mem_a_q <= addr_q + {29'd0, rd_next_d};
                    end
                    if (cnt_q == nbytes_q) begin
                        state_q <= ST_DONE;
                        mem_a_q <= 32'd0;
                        if (state_q == ST_IFETCH) begin
                            ic_valid_q <= 1'b1;
                            ic_inst_q  <= buf_d;
                        end else begin
                            ls_done_q  <= 1'b1;
                            ls_rdata_q <= ext_d;
                        end
                    end
                end
                ST_STORE: begin
                    cnt_q <= st_idx_d;
                    if (st_idx_d == nbytes_q) begin
                        state_q   <= ST_DONE;
                        wr_q      <= 1'b0;
                        mem_a_q   <= 32'd0;
                        dout_q    <= 8'd0;
                        ls_done_q <= 1'b1;
                    end else begin
                        mem_a_q <= addr_q + {29'd0, st_idx_d};
                        dout_q  <= wdata_q[{st_idx_d[1:0], 3'b000} +: 8];
                        wr_q    <= !io_stall;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    cnt_q      <= 3'd0;
                    ic_valid_q <= 1'b0;
                    ls_done_q  <= 1'b0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_a    = mem_a_q;
    assign mem_dout = dout_q;
    assign mem_wr   = wr_q & rdy_in;
    assign ic_valid = ic_valid_q;
    assign ic_inst  = ic_inst_q;
    assign ls_done  = ls_done_q;
    assign ls_rdata = ls_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: directed requests push expected completions
// and writes (with their cycle) into queues drained by a negedge monitor.
module tb_mem_ctrl;

    typedef struct {
        int          kind;   // 0 fetch, 1 load, 2 store
        logic [31:0] data;
        int          cyc;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;
    logic        ic_ask;
    logic [31:0] ic_addr;
    logic        ic_valid;
    logic [31:0] ic_inst;
    logic        ls_ask;
    logic        ls_wr;
    logic [1:0]  ls_size;
    logic        ls_signed;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    rsp_t mon_r;
    wr_t  mon_w;
    logic [7:0] ram [0:4095];

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full),
        .ic_ask         (ic_ask),
        .ic_addr        (ic_addr),
        .ic_valid       (ic_valid),
        .ic_inst        (ic_inst),
        .ls_ask         (ls_ask),
        .ls_wr          (ls_wr),
        .ls_size        (ls_size),
        .ls_signed      (ls_signed),
        .ls_addr        (ls_addr),
        .ls_wdata       (ls_wdata),
        .ls_done        (ls_done),
        .ls_rdata       (ls_rdata)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // 4 KiB RAM aliased on mem_a[11:0], one-cycle read latency.
    always @(posedge clk_in) begin
        if (cyc == 0) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h13; ram[12'h101] <= 8'h05;
            ram[12'h102] <= 8'h10; ram[12'h103] <= 8'h00;
            ram[12'h120] <= 8'h34; ram[12'h121] <= 8'hF2;
            ram[12'h122] <= 8'h7F; ram[12'h123] <= 8'h81;
            ram[12'h140] <= 8'h80;
            ram[12'hFFF] <= 8'hAA; ram[12'h000] <= 8'hBB;
            ram[12'h001] <= 8'hCC; ram[12'h002] <= 8'hDD;
            mem_din <= 8'h00;
        end else begin
            mem_din <= ram[mem_a[11:0]];
            if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
        end
    end

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void exp_rsp(input int kind, input logic [31:0] data, input int c);
        rsp_t r;
        r.kind = kind; r.data = data; r.cyc = c;
        rsp_q.push_back(r);
    endfunction

    function automatic void exp_wr(input logic [31:0] addr, input logic [7:0] data, input int c);
        wr_t w;
        w.addr = addr; w.data = data; w.cyc = c;
        wr_q.push_back(w);
    endfunction

    always @(negedge clk_in) begin
        if (ic_valid && ls_done) check("pulse_exclusive", 32'd1, 32'd0);
        if (rst_in && rdy_in && (ic_valid || ls_done)) begin
            if (rsp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, ls_done, ic_valid}, 32'd0);
            end else begin
                mon_r = rsp_q.pop_front();
                check("rsp_is_fetch", {31'd0, ic_valid}, {31'd0, mon_r.kind == 0});
                check("rsp_cycle", 32'(cyc), 32'(mon_r.cyc));
                if (mon_r.kind == 0) check("ic_inst", ic_inst, mon_r.data);
                if (mon_r.kind == 1) check("ls_rdata", ls_rdata, mon_r.data);
            end
        end
        if (mem_wr) begin
            if (wr_q.size() == 0) begin
                check("unexpected_write", mem_a, 32'hFFFF_FFFF);
            end else begin
                mon_w = wr_q.pop_front();
                check("wr_addr", mem_a, mon_w.addr);
                check("wr_data", {24'd0, mem_dout}, {24'd0, mon_w.data});
                check("wr_cycle", 32'(cyc), 32'(mon_w.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Returns one edge after the pulse was seen, ready to drop the ask.
    task automatic wait_flag(input bit is_ic);
        int n = 0;
        while (!((is_ic ? ic_valid : ls_done) && rdy_in) && n < 40) begin
            @(negedge clk_in);
            n++;
        end
        check(is_ic ? "fetch_timeout" : "ls_timeout", {31'd0, n < 40}, 32'd1);
        tick();
    endtask

    task automatic ls_req(input bit wr, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
        ls_wr = wr; ls_size = size; ls_signed = sgn;
        ls_addr = addr; ls_wdata = wdata; ls_ask = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_ic_valid"}, {31'd0, ic_valid}, 32'd0);
        check({tag, "_ic_inst"}, ic_inst, 32'd0);
        check({tag, "_ls_done"}, {31'd0, ls_done}, 32'd0);
        check({tag, "_ls_rdata"}, ls_rdata, 32'd0);
    endtask

    initial begin
        int c;
        rst_in = 1'b0; rdy_in = 1'b1; io_buffer_full = 1'b0;
        ic_ask = 1'b0; ic_addr = 32'd0;
        ls_ask = 1'b0; ls_wr = 1'b0; ls_size = 2'd0; ls_signed = 1'b0;
        ls_addr = 32'd0; ls_wdata = 32'd0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_in = 1'b1;
        tick();

        // Instruction fetch, then confirm no second fetch once ask drops
        c = cyc; exp_rsp(0, 32'h0010_0513, c + 6);
        ic_addr = 32'h100; ic_ask = 1'b1;
        wait_flag(1); ic_ask = 1'b0;
        repeat (3) tick();
        check("no_refetch_mem_a", mem_a, 32'd0);
        check("no_refetch_valid", {31'd0, ic_valid}, 32'd0);

        c = cyc; exp_rsp(1, 32'hFFFF_FF80, c + 3);
        ls_req(0, 2'd0, 1, 32'h140, 32'd0); wait_flag(0); ls_ask = 1'b0; tick();

        c = cyc; exp_rsp(1, 32'h0000_0080, c + 3);
        ls_req(0, 2'd0, 0, 32'h140, 32'd0); wait_flag(0); ls_ask = 1'b0; tick();

        // Signed half load with the done pulse stretched by rdy_in low
        c = cyc; exp_rsp(1, 32'hFFFF_F234, c + 6);
        ls_req(0, 2'd1, 1, 32'h120, 32'd0);
        repeat (4) tick();
        rdy_in = 1'b0;
        repeat (2) tick();
        check("done_stretched", {31'd0, ls_done}, 32'd1);
        rdy_in = 1'b1;
        tick(); ls_ask = 1'b0; tick();

        c = cyc; exp_rsp(1, 32'h0000_817F, c + 4);
        ls_req(0, 2'd1, 0, 32'h122, 32'd0); wait_flag(0); ls_ask = 1'b0; tick();

        c = cyc;
        exp_wr(32'h200, 8'hEF, c + 1); exp_wr(32'h201, 8'hBE, c + 2);
        exp_wr(32'h202, 8'hAD, c + 3); exp_wr(32'h203, 8'hDE, c + 4);
        exp_rsp(2, 32'd0, c + 5);
        ls_req(1, 2'd2, 0, 32'h200, 32'hDEAD_BEEF); wait_flag(0); ls_ask = 1'b0; tick();

        c = cyc; exp_rsp(1, 32'hDEAD_BEEF, c + 6);
        ls_req(0, 2'd2, 0, 32'h200, 32'd0); wait_flag(0); ls_ask = 1'b0; tick();

        // Simultaneous asks: load first, fetch accepted after DONE
        c = cyc;
        exp_rsp(1, 32'h0000_0080, c + 3);
        exp_rsp(0, 32'h0010_0513, c + 10);
        ls_req(0, 2'd0, 0, 32'h140, 32'd0);
        ic_addr = 32'h100; ic_ask = 1'b1;
        wait_flag(0); ls_ask = 1'b0;
        wait_flag(1); ic_ask = 1'b0; tick();

        // Half store frozen by rdy_in between its two bytes
        c = cyc;
        exp_wr(32'h210, 8'h34, c + 1); exp_wr(32'h211, 8'h12, c + 4);
        exp_rsp(2, 32'd0, c + 5);
        ls_req(1, 2'd1, 0, 32'h210, 32'hABCD_1234);
        repeat (2) tick();
        rdy_in = 1'b0;
        tick();
        check("frozen_no_write", {31'd0, mem_wr}, 32'd0);
        tick();
        rdy_in = 1'b1;
        wait_flag(0); ls_ask = 1'b0; tick();

        c = cyc; exp_rsp(1, 32'hDDCC_BBAA, c + 6);
        ls_req(0, 2'd2, 0, 32'hFFFF_FFFF, 32'd0); wait_flag(0); ls_ask = 1'b0; tick();

        // IO store stalled for three cycles by io_buffer_full
        c = cyc;
        exp_wr(32'h0003_0000, 8'h5A, c + 4);
        exp_rsp(2, 32'd0, c + 5);
        io_buffer_full = 1'b1;
        ls_req(1, 2'd0, 0, 32'h0003_0000, 32'h0000_005A);
        tick();
        check("io_stall_no_write", {31'd0, mem_wr}, 32'd0);
        repeat (2) tick();
        io_buffer_full = 1'b0;
        wait_flag(0); ls_ask = 1'b0; tick();

        // Reset in the middle of a fetch, then the held ask is served again
        ic_addr = 32'h100; ic_ask = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("midreset");
        repeat (2) tick();
        rst_in = 1'b1;
        c = cyc; exp_rsp(0, 32'h0010_0513, c + 6);
        wait_flag(1); ic_ask = 1'b0;

        repeat (5) tick();
        check("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        check("wr_queue_drained", 32'(wr_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
